// File: rtl/eth_pkg.sv
// Shared Ethernet constants: CRC-32 parameters, frame field lengths and FCS FSM states.
package eth_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT    = 32'hFFFFFFFF;

  localparam int unsigned ETH_PREAMBLE_LEN = 8;
  localparam int unsigned ETH_FCS_LEN      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fcs_state_e;

endpackage

// File: rtl/crc32_byte_step.sv
// One byte of reflected CRC-32 (LSB first), eight serial steps unrolled combinationally.
module crc32_byte_step
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC32_POLY_REFL) : (crc_out >> 1);
    end
  end

endmodule

// File: rtl/eth_fcs_calc.sv
// Sweeps the frame RAM from the first post-preamble octet to the last payload octet
// and produces the Ethernet FCS once per reset.
module eth_fcs_calc
  import eth_pkg::*;
#(
  parameter int unsigned ETH_FRAME_SIZE = 70,
  parameter int unsigned PREAMBLE_LEN   = ETH_PREAMBLE_LEN,
  parameter int unsigned ADDR_W         = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       crc,
  output logic              finish,
  output logic              busy
);

  localparam int unsigned FIRST = PREAMBLE_LEN;
  localparam int unsigned LAST  = ETH_FRAME_SIZE - ETH_FCS_LEN - 1;
  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST);

  if (ETH_FRAME_SIZE <= PREAMBLE_LEN + ETH_FCS_LEN) begin : g_bad_frame_size
    $error("eth_fcs_calc: frame too small to cover any payload octet");
  end
  if (64'(ETH_FRAME_SIZE) > (64'(1) << ADDR_W)) begin : g_bad_addr_w
    $error("eth_fcs_calc: ADDR_W too narrow for ETH_FRAME_SIZE");
  end

  fcs_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       acc_q, acc_d;
  logic [31:0]       crc_q, crc_d;
  logic              finish_q, finish_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;
  logic              valid_q, valid_d;
  logic [31:0]       step_out;
  logic              start_edge;

  crc32_byte_step u_step (
    .crc_in  (acc_q),
    .data    (ram_data),
    .crc_out (step_out)
  );

  assign start_edge = start & ~start_q;

  // Next-state: valid_q marks the cycle in which ram_data answers last cycle's address.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    acc_d    = acc_q;
    crc_d    = crc_q;
    finish_d = finish_q;
    start_d  = start;
    valid_d  = 1'b0;

    if (valid_q) begin
      acc_d = step_out;
    end

    case (state_q)
      ST_IDLE: begin
        addr_d = FIRST_A;
        if (start_edge) begin
          acc_d   = CRC32_INIT;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        valid_d = 1'b1;
        if (addr_q == LAST_A) begin
          state_d = ST_DRAIN;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        crc_d    = acc_q ^ CRC32_XOROUT;
        finish_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_READ) || (state_d == ST_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      acc_q    <= CRC32_INIT;
      crc_q    <= '0;
      finish_q <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      acc_q    <= acc_d;
      crc_q    <= crc_d;
      finish_q <= finish_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      valid_q  <= valid_d;
    end
  end

  assign ram_addr = addr_q;
  assign crc      = crc_q;
  assign finish   = finish_q;
  assign busy     = busy_q;

endmodule
